mux_scan: RTL
=============

# mux_scan

Registered, parametrised N-channel, W-bit multiplexer with a valid/ready output stage and an optional auto-scan mode. It generalises the lab's fixed 8x1 single-bit mux: any channel count and data width, a registered output with one-cycle latency, and backpressure. It sits between a bank of parallel sources (switches, counters, sensor registers) and a single serial consumer such as a display driver or UART feeder.

## Interface
- `WIDTH`, 8, data bits per channel (>=1)
- `CHANNELS`, 8, number of input channels (>=2; need not be a power of two)
- `SEL_W`, `$clog2(CHANNELS)`, select/channel-index width (derived, do not override)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in`  in  CHANNELS*WIDTH  packed channels; channel k = `in[k*WIDTH +: WIDTH]`
- `sel`  in  SEL_W  manual channel select
- `load`  in  1  manual-mode sample request
- `mode`  in  1  0 = manual, 1 = scan (only when `MUX_SCAN_EN` is defined)
- `out`  out  WIDTH  captured data
- `out_ch`  out  SEL_W  channel index of `out`
- `out_valid`  out  1  `out`/`out_ch` hold an untransferred sample
- `out_ready`  in  1  consumer accepts the sample

## Operation
- Two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- Transfer: `out_valid && out_ready` in the same cycle.
- Slot free: EMPTY, or FULL with a transfer this cycle.
- Sample condition:
  - manual: `load && slot free`
  - scan: `slot free` (no `load` needed)
- On sample: `out` <= channel data, `out_ch` <= channel index, state -> FULL.
- On transfer with no sample: state -> EMPTY. `out`/`out_ch` keep their last values.
- Manual channel = `sel`. If `sel >= CHANNELS`: `out` <= 0, `out_ch` <= `sel`, still valid.
- Scan channel = internal pointer `scan_ptr`. After each scan sample, `scan_ptr` increments and wraps from CHANNELS-1 to 0.
  - `scan_ptr` <= 0 whenever `mode`=0.
  - The first scan sample after entering scan mode is therefore channel 0.
- `load` is ignored when the slot is not free; there is no queueing.
- `load` and `sel` are ignored while `mode`=1.
- Mode change while FULL: the held sample is unaffected. The new mode applies to the next sample.

## Timing
- Reset values: `out`=0, `out_ch`=0, `out_valid`=0, `scan_ptr`=0. `rst` overrides every other input in that cycle, including mid-transfer; the held sample is discarded.
- Latency: sample cycle N -> `out_valid`=1 and data visible after edge N (cycle N+1).
- Throughput: one sample per cycle when `out_ready` is held at 1 (back-to-back transfer and sample).
- Stall: while `out_valid && !out_ready`, `out`, `out_ch` and `out_valid` are stable.
- `in` is sampled only on the sample edge. Later changes do not alter the held `out`.
- `out_valid` never drops without a transfer or a reset.

## Configuration
- `MUX_SCAN_EN` defined: `mode` port and `scan_ptr` exist; scan behaviour as above.
- Not defined: no `mode` port; the block is permanently manual and no scan logic is built. Manual behaviour is identical.

## Test plan
- Reset: assert `rst` 2 cycles with `load`=1 -> `out_valid`=0, `out`=0, `out_ch`=0 throughout.
- Manual walking one (WIDTH=8, CHANNELS=8, `out_ready`=1):
  - set channel k = 8'hA0+k, `sel`=k, pulse `load` -> next cycle `out`=A0+k, `out_ch`=k, `out_valid`=1, for k=0..7.
  - channel 3 = 0 with `sel`=3 -> `out`=0.
- Backpressure: `out_ready`=0, load `sel`=2 (8'h55), then `load` with `sel`=5 for 3 cycles and change `in` -> `out` stays 55, `out_ch` stays 2. Raise `out_ready` -> transfer, then EMPTY.
- Out-of-range (CHANNELS=5, SEL_W=3): `sel`=6, `load` -> `out`=0, `out_ch`=6, `out_valid`=1.
- Scan (`MUX_SCAN_EN`, `out_ready`=1, `mode`=1 for 10 cycles) -> `out_ch` sequence 0,1,...,7,0,1, one per cycle.
  - Drop `out_ready` at `out_ch`=4 -> holds at 4.
  - Release -> continues at 5.
- Mode switch: in scan at `out_ch`=3, set `mode`=0 for 1 cycle, then `mode`=1 -> the next scan sample is channel 0.

Source files
------------

// File: rtl/mux_scan_if.sv
// mux_scan_if: channel bank, select and valid/ready output bundle for mux_scan.
// The mode signal exists only when MUX_SCAN_EN is defined.
interface mux_scan_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in;
    logic [SEL_W-1:0]          sel;
    logic                      load;
`ifdef MUX_SCAN_EN
    logic                      mode;
`endif
    logic [WIDTH-1:0]          out;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      out_ready;

    // Source/consumer side
    modport master (
        output in, sel, load,
`ifdef MUX_SCAN_EN
        output mode,
`endif
        output out_ready,
        input  out, out_ch, out_valid
    );

    // Multiplexer side
    modport slave (
        input  in, sel, load,
`ifdef MUX_SCAN_EN
        input  mode,
`endif
        input  out_ready,
        output out, out_ch, out_valid
    );
endinterface

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit multiplexer with a one-deep valid/ready output slot.
// Optional auto-scan mode is built only when MUX_SCAN_EN is defined.
module mux_scan #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8
) (
    input logic       clk,
    input logic       rst,
    mux_scan_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             valid_q, valid_d;

    logic             slot_free;
    logic             sample;
    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] ch_data;

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;

    // Scan mode samples whenever the slot frees; manual mode needs load
    always_comb begin
        slot_free = !valid_q || bus.out_ready;
        sample    = slot_free && (bus.mode || bus.load);
        ch        = bus.mode ? scan_ptr_q : bus.sel;
    end

    // Pointer is parked at 0 outside scan mode so scanning always restarts at channel 0
    always_comb begin
        scan_ptr_d = scan_ptr_q;
        if (!bus.mode) begin
            scan_ptr_d = '0;
        end else if (sample) begin
            scan_ptr_d = (scan_ptr_q == SEL_W'(CHANNELS - 1)) ? '0 : scan_ptr_q + 1'b1;
        end
    end

    // Scan pointer register
    always_ff @(posedge clk) begin
        if (rst) scan_ptr_q <= '0;
        else     scan_ptr_q <= scan_ptr_d;
    end
`else
    // Manual-only sample decision
    always_comb begin
        slot_free = !valid_q || bus.out_ready;
        sample    = slot_free && bus.load;
        ch        = bus.sel;
    end
`endif

    // Channel select; indices past the last channel read as zero
    always_comb begin
        ch_data = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (ch == SEL_W'(k)) ch_data = bus.in[k*WIDTH +: WIDTH];
        end
    end

    // Output slot next state: sample refills, bare transfer empties, otherwise hold
    always_comb begin
        out_d    = out_q;
        out_ch_d = out_ch_q;
        valid_d  = valid_q;
        if (sample) begin
            out_d    = ch_data;
            out_ch_d = ch;
            valid_d  = 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_d  = 1'b0;
        end
    end

    // Output slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            out_ch_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            out_q    <= out_d;
            out_ch_q <= out_ch_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = valid_q;
endmodule
